// File: rtl/alu_sequencer.sv
// Four-state sequencer (IDLE/FETCH/EXEC/DONE) that decodes an opcode, fetches its operand and issues ALU control.
// Optional CB-prefixed decode is built only when ALU_SEQ_CB_EN is defined.
module alu_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Enable,
  input  logic       i_Start,
  input  logic [7:0] i_Opcode,
  input  logic       i_CB_Prefix,
  input  logic [7:0] i_Operand,
  input  logic       i_Operand_Valid,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Error,
  output logic       o_Operand_Req,
  output logic [2:0] o_Src_Sel,
  output logic [7:0] o_Opcode,
  output logic [7:0] o_Parameter,
  output logic [1:0] o_Read,
  output logic [1:0] o_Write,
  output logic [5:0] o_Function_Control,
  output logic       o_Save_Flags,
  output logic       o_Dest_Write,
  output logic [2:0] o_Dest_Sel,
  output logic       o_Mem_Write
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_REG, DST_MEM} dst_t;

  localparam logic [5:0] FC_MAIN  = 6'b000001;
  localparam logic [5:0] FC_INC   = 6'b000010;
  localparam logic [5:0] FC_DEC   = 6'b000110;
  localparam logic [5:0] FC_LOGIC = 6'b001000;
  localparam logic [5:0] FC_ROT   = 6'b011000;
  localparam logic [5:0] FC_MISC  = 6'b100000;

  state_t     state, state_nxt;
  logic       dec_ok, dec_fetch;
  logic [5:0] dec_fc;
  logic [2:0] dec_src, dec_dsel;
  dst_t       dec_dst;

  logic [7:0] opcode_q, param_q;
  logic [5:0] fc_q;
  logic [2:0] src_q, dsel_q;
  dst_t       dst_q;
  logic       err_q;

  // Register code 111 is the accumulator, 110 is memory at (HL).
  function automatic dst_t dst_of(input logic [2:0] code);
    if (code == 3'b111)      return DST_A;
    else if (code == 3'b110) return DST_MEM;
    else                     return DST_REG;
  endfunction

  always_comb begin
    dec_ok    = 1'b0;
    dec_fetch = 1'b1;
    dec_fc    = '0;
    dec_src   = '0;
    dec_dsel  = '0;
    dec_dst   = DST_NONE;
    if (i_CB_Prefix) begin
`ifdef ALU_SEQ_CB_EN
      if (i_Opcode[7:6] == 2'b00) begin
        dec_ok   = 1'b1;
        dec_fc   = FC_LOGIC;
        dec_src  = i_Opcode[2:0];
        dec_dsel = i_Opcode[2:0];
        dec_dst  = dst_of(i_Opcode[2:0]);
      end
`endif
    end else begin
      casez (i_Opcode)
        8'b10??????, 8'b11???110: begin
          dec_ok   = 1'b1;
          dec_fc   = FC_MAIN;
          dec_src  = i_Opcode[6] ? 3'b110 : i_Opcode[2:0];
          dec_dsel = 3'b111;
          dec_dst  = (i_Opcode[5:3] == 3'b111) ? DST_NONE : DST_A;
        end
        8'b00???10?: begin
          dec_ok   = 1'b1;
          dec_fc   = i_Opcode[0] ? FC_DEC : FC_INC;
          dec_src  = i_Opcode[5:3];
          dec_dsel = i_Opcode[5:3];
          dec_dst  = dst_of(i_Opcode[5:3]);
        end
        8'b000??111: begin
          dec_ok   = 1'b1;
          dec_fc   = FC_ROT;
          dec_src  = 3'b111;
          dec_dsel = 3'b111;
          dec_dst  = DST_A;
        end
        8'b001??111: begin
          dec_ok    = 1'b1;
          dec_fetch = 1'b0;
          dec_fc    = FC_MISC;
          dec_src   = 3'b111;
          dec_dsel  = 3'b111;
          dec_dst   = DST_A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else if (i_Enable) state <= state_nxt;
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      opcode_q <= '0;
      param_q  <= '0;
      fc_q     <= '0;
      src_q    <= '0;
      dsel_q   <= '0;
      dst_q    <= DST_NONE;
      err_q    <= 1'b0;
    end else if (i_Enable) begin
      if (state == IDLE && i_Start) begin
        opcode_q <= i_Opcode;
        fc_q     <= dec_ok ? dec_fc : 6'b0;
        src_q    <= dec_ok ? dec_src : 3'b0;
        dsel_q   <= dec_ok ? dec_dsel : 3'b0;
        dst_q    <= dec_ok ? dec_dst : DST_NONE;
        err_q    <= !dec_ok;
      end
      if (state == FETCH && i_Operand_Valid) param_q <= i_Operand;
    end
  end

  always_comb begin
    state_nxt          = state;
    o_Busy             = (state != IDLE);
    o_Done             = 1'b0;
    o_Error            = 1'b0;
    o_Operand_Req      = 1'b0;
    o_Src_Sel          = src_q;
    o_Opcode           = opcode_q;
    o_Parameter        = param_q;
    o_Read             = 2'b00;
    o_Write            = 2'b00;
    o_Function_Control = '0;
    o_Save_Flags       = 1'b0;
    o_Dest_Write       = 1'b0;
    o_Dest_Sel         = '0;
    o_Mem_Write        = 1'b0;
    case (state)
      IDLE: begin
        if (i_Start) begin
          if (!dec_ok)        state_nxt = DONE;
          else if (dec_fetch) state_nxt = FETCH;
          else                state_nxt = EXEC;
        end
      end
      FETCH: begin
        o_Operand_Req = 1'b1;
        if (i_Operand_Valid) state_nxt = EXEC;
      end
      EXEC: begin
        o_Function_Control = fc_q;
        o_Save_Flags       = 1'b1;
        o_Write            = {1'b0, dst_q == DST_A};
        o_Dest_Write       = (dst_q == DST_REG);
        o_Dest_Sel         = (dst_q == DST_REG) ? dsel_q : 3'b0;
        o_Mem_Write        = (dst_q == DST_MEM);
        state_nxt          = DONE;
      end
      DONE: begin
        o_Done    = 1'b1;
        o_Error   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized checks of alu_sequencer against an opcode-table reference model.
module tb_alu_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n = 1'b1;
  logic       i_Enable = 1'b1;
  logic       i_Start = 1'b0;
  logic [7:0] i_Opcode = '0;
  logic       i_CB_Prefix = 1'b0;
  logic [7:0] i_Operand = '0;
  logic       i_Operand_Valid = 1'b0;
  logic       o_Busy, o_Done, o_Error, o_Operand_Req;
  logic [2:0] o_Src_Sel;
  logic [7:0] o_Opcode, o_Parameter;
  logic [1:0] o_Read, o_Write;
  logic [5:0] o_Function_Control;
  logic       o_Save_Flags, o_Dest_Write;
  logic [2:0] o_Dest_Sel;
  logic       o_Mem_Write;

  int n_chk = 0;
  int n_fail = 0;

  alu_sequencer dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Enable(i_Enable), .i_Start(i_Start),
    .i_Opcode(i_Opcode), .i_CB_Prefix(i_CB_Prefix), .i_Operand(i_Operand),
    .i_Operand_Valid(i_Operand_Valid), .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error),
    .o_Operand_Req(o_Operand_Req), .o_Src_Sel(o_Src_Sel), .o_Opcode(o_Opcode),
    .o_Parameter(o_Parameter), .o_Read(o_Read), .o_Write(o_Write),
    .o_Function_Control(o_Function_Control), .o_Save_Flags(o_Save_Flags),
    .o_Dest_Write(o_Dest_Write), .o_Dest_Sel(o_Dest_Sel), .o_Mem_Write(o_Mem_Write)
  );

  always #5 i_Clk = ~i_Clk;

  wire [38:0] all_out = {o_Busy, o_Done, o_Error, o_Operand_Req, o_Src_Sel, o_Opcode, o_Parameter,
                         o_Read, o_Write, o_Function_Control, o_Save_Flags, o_Dest_Write,
                         o_Dest_Sel, o_Mem_Write};

  typedef struct {
    bit       ok;
    bit       fetch;
    bit [5:0] fc;
    bit [2:0] src;
    bit       wr_a;
    bit       wr_reg;
    bit       wr_mem;
    bit [2:0] dsel;
  } exp_t;

  // Expected behaviour per opcode, derived from the opcode-pattern table.
  function automatic exp_t model(input logic [7:0] op, input logic cb);
    exp_t e;
    int r, mid, dest;
    e = '{default: 0};
    r = op & 7;
    mid = (op >> 3) & 7;
    dest = -1;
    if (cb) begin
`ifdef ALU_SEQ_CB_EN
      if (op < 8'h40) begin
        e.ok = 1; e.fetch = 1; e.fc = 6'h08; e.src = 3'(r); dest = r;
      end
`endif
    end else if ((op & 8'hC0) == 8'h80 || (op & 8'hC7) == 8'hC6) begin
      e.ok = 1; e.fetch = 1; e.fc = 6'h01;
      e.src = (op >= 8'hC0) ? 3'd6 : 3'(r);
      dest = (mid == 7) ? -1 : 7;
    end else if ((op & 8'hC7) == 8'h04 || (op & 8'hC7) == 8'h05) begin
      e.ok = 1; e.fetch = 1; e.fc = (op % 2 == 1) ? 6'h06 : 6'h02; e.src = 3'(mid); dest = mid;
    end else if ((op & 8'hE7) == 8'h07) begin
      e.ok = 1; e.fetch = 1; e.fc = 6'h18; e.src = 3'd7; dest = 7;
    end else if ((op & 8'hE7) == 8'h27) begin
      e.ok = 1; e.fetch = 0; e.fc = 6'h20; dest = 7;
    end
    if (dest == 7)      e.wr_a = 1;
    else if (dest == 6) e.wr_mem = 1;
    else if (dest >= 0) begin e.wr_reg = 1; e.dsel = 3'(dest); end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk_exec(input exp_t e, input logic [7:0] op, input logic [7:0] opnd);
    chk("exec_fc", 32'(o_Function_Control), 32'(e.fc));
    chk("exec_save", 32'(o_Save_Flags), 1);
    chk("exec_write", 32'(o_Write), 32'(e.wr_a));
    chk("exec_dwr", 32'(o_Dest_Write), 32'(e.wr_reg));
    chk("exec_dsel", 32'(o_Dest_Sel), 32'(e.wr_reg ? e.dsel : 3'd0));
    chk("exec_mem", 32'(o_Mem_Write), 32'(e.wr_mem));
    chk("exec_read", 32'(o_Read), 0);
    chk("exec_opcode", 32'(o_Opcode), 32'(op));
    chk("exec_done", 32'(o_Done), 0);
    chk("exec_req", 32'(o_Operand_Req), 0);
    chk("exec_busy", 32'(o_Busy), 1);
    if (e.fetch) chk("exec_param", 32'(o_Parameter), 32'(opnd));
  endtask

  // One full transaction starting from IDLE; delay = FETCH cycles before valid, gap = disabled EXEC cycles.
  task automatic run_op(input logic [7:0] op, input logic cb, input logic [7:0] opnd,
                        input int delay, input int gap);
    exp_t e;
    e = model(op, cb);
    chk("idle_busy", 32'(o_Busy), 0);
    i_Start = 1; i_Opcode = op; i_CB_Prefix = cb;
    i_Operand = 8'($urandom); i_Operand_Valid = 1'($urandom_range(0, 1));
    step();
    i_Start = 1'($urandom_range(0, 1)); i_Opcode = 8'($urandom); i_CB_Prefix = 1'($urandom);
    i_Operand_Valid = 0;
    if (!e.ok) begin
      chk("unsup_done", 32'(o_Done), 1);
      chk("unsup_err", 32'(o_Error), 1);
      chk("unsup_fc", 32'(o_Function_Control), 0);
      chk("unsup_wr", 32'({o_Write, o_Dest_Write, o_Mem_Write, o_Save_Flags}), 0);
    end else begin
      if (e.fetch) begin
        for (int k = 0; k <= delay; k++) begin
          chk("fetch_req", 32'(o_Operand_Req), 1);
          chk("fetch_src", 32'(o_Src_Sel), 32'(e.src));
          chk("fetch_save", 32'(o_Save_Flags), 0);
          chk("fetch_done", 32'(o_Done), 0);
          i_Operand_Valid = (k == delay);
          i_Operand = (k == delay) ? opnd : 8'($urandom);
          step();
        end
        i_Operand_Valid = 0;
        i_Operand = 8'($urandom);
      end
      chk_exec(e, op, opnd);
      i_Enable = 0;
      for (int g = 0; g < gap; g++) begin
        step();
        chk_exec(e, op, opnd);
      end
      i_Enable = 1;
      step();
      chk("done_pulse", 32'(o_Done), 1);
      chk("done_err", 32'(o_Error), 0);
      chk("done_wr", 32'({o_Function_Control, o_Write, o_Dest_Write, o_Mem_Write, o_Save_Flags}), 0);
    end
    step();
    i_Start = 0;
    chk("back_idle", 32'(o_Busy), 0);
    chk("done_once", 32'(o_Done), 0);
  endtask

  initial begin
    #2 i_Reset_n = 0;
    #1 chk("reset_outs", 32'(|all_out), 0);
    #5 i_Reset_n = 1;
    step();
    chk("post_reset_busy", 32'(o_Busy), 0);

    run_op(8'h80, 0, 8'h12, 0, 0);
    run_op(8'h35, 0, 8'hA7, 4, 0);
    run_op(8'hBE, 0, 8'h3C, 1, 0);
    run_op(8'h2F, 0, 8'h00, 0, 0);
    run_op(8'h76, 0, 8'h55, 0, 0);
    run_op(8'h11, 1, 8'h99, 0, 0);
    run_op(8'h3C, 0, 8'h01, 0, 0);
    run_op(8'hFE, 0, 8'h42, 2, 0);
    run_op(8'h80, 0, 8'h5A, 0, 3);

    // Reset while waiting in FETCH: immediate IDLE, no writeback or done afterwards.
    i_Start = 1; i_Opcode = 8'h35; i_CB_Prefix = 0;
    step();
    i_Start = 0;
    chk("pre_rst_req", 32'(o_Operand_Req), 1);
    #2 i_Reset_n = 0;
    #1 chk("midop_rst_outs", 32'(|all_out), 0);
    i_Operand_Valid = 1; i_Operand = 8'h77;
    step();
    chk("rst_hold_outs", 32'(|all_out), 0);
    #3 i_Reset_n = 1;
    i_Operand_Valid = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("after_rst_quiet", 32'({o_Busy, o_Done, o_Mem_Write, o_Save_Flags}), 0);
    end

    for (int n = 0; n < 60; n++)
      run_op(8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
